fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter p_depth, default 480: number of framebuffer words; valid addresses are 0..p_depth-1.
REQ-002 SHALL have parameter p_addr_width, default $clog2(p_depth) (9): address width.
REQ-003 SHALL have parameter p_data_width, default 1: framebuffer word width.
REQ-004 SHALL have parameter p_clear_value, default 0: word written during a clear sweep.
REQ-005 SHALL have port i_clk_pixel, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_clear_req, input, 1: single-cycle request to sweep-clear the framebuffer.
REQ-008 SHALL have ports i_valid[2], input, 1 each: write requests from port 0 (sensor loader) and port 1 (overlay).
REQ-009 SHALL have ports i_addr[2], input, p_addr_width each: write addresses of the requesters.
REQ-010 SHALL have ports i_data[2], input, p_data_width each: write data of the requesters.
REQ-011 SHALL have ports o_ready[2], output, 1 each: grant; a transfer on port k occurs when i_valid[k] & o_ready[k].
REQ-012 SHALL have port o_we, output, 1: write enable to the framebuffer write port.
REQ-013 SHALL have port o_waddr, output, p_addr_width: framebuffer write address.
REQ-014 SHALL have port o_wdata, output, p_data_width: framebuffer write data.
REQ-015 SHALL have port o_busy, output, 1: high while a clear sweep is in progress.
REQ-016 SHALL have port o_clear_done, output, 1: single-cycle pulse when a clear sweep completes.
REQ-017 SHALL have port o_drop_cnt, output, 8: saturating count of accepted out-of-range writes.

Function
REQ-018 SHALL implement an FSM with states S_RUN, S_CLEAR and S_DONE.
REQ-019 SHALL, in S_RUN with i_clear_req high, move to S_CLEAR on the next edge, load the clear address counter with 0 and grant no requester in that cycle.
REQ-020 SHALL, in S_CLEAR, drive o_we=1, o_waddr=counter and o_wdata=p_clear_value once per cycle, incrementing the counter by 1.
REQ-021 SHALL, after the write of address p_depth-1, go to S_DONE, so that exactly p_depth clear writes occur with no gaps.
REQ-022 SHALL pulse o_clear_done for the one cycle spent in S_DONE, then return to S_RUN.
REQ-023 SHALL ignore i_clear_req while in S_CLEAR or S_DONE: no restart, no queueing.
REQ-024 SHALL hold o_ready[0] and o_ready[1] low in S_CLEAR and S_DONE, and in the S_RUN cycle where i_clear_req is high.
REQ-025 SHALL, in S_RUN, derive o_ready combinationally from i_valid and a round-robin pointer rr; at most one o_ready is high.
REQ-026 SHALL grant a single valid requester regardless of rr.
REQ-027 SHALL grant port rr when both requesters are valid.
REQ-028 SHALL, after a grant to port k, set rr to 1-k; rr is unchanged in cycles with no transfer.
REQ-029 SHALL register an accepted transfer to o_we, o_waddr and o_wdata with exactly 1-cycle latency.
REQ-030 SHALL accept, but not write (o_we=0), a transfer with i_addr >= p_depth, and increment o_drop_cnt, saturating at 255.
REQ-031 SHALL drive o_we=0, and hold o_waddr and o_wdata at their last values, in cycles with no transfer and no clear write.
REQ-032 SHALL sustain full throughput: one write per cycle in S_RUN when any requester is continuously valid.
REQ-033 SHALL keep the registered output of a transfer accepted in the cycle before entering S_CLEAR; that write is emitted before the first clear write.

Reset
REQ-034 SHALL, on i_rst_n low, asynchronously set the state to S_RUN, rr=0, clear counter=0, o_we=0, o_waddr=0, o_wdata=0, o_busy=0, o_clear_done=0, o_drop_cnt=0 and o_ready=0.
REQ-035 SHALL abort a clear sweep in progress on reset without producing o_clear_done; the first valid request after reset release is granted in the next S_RUN cycle.

Verification
REQ-036 SHALL cover: port 0 only valid with addr 5, data 1 -> o_ready[0]=1, next cycle o_we=1, o_waddr=5, o_wdata=1.
REQ-037 SHALL cover: both ports valid continuously for 4 cycles after reset -> grants 0,1,0,1, four consecutive o_we pulses.
REQ-038 SHALL cover: i_clear_req pulse with p_depth=480 -> o_busy high 480 cycles, addresses 0..479 written with 0, then o_clear_done for 1 cycle, and o_ready low throughout.
REQ-039 SHALL cover: i_clear_req pulsed again at clear address 100 -> sweep unaffected, exactly 480 clear writes, one o_clear_done.
REQ-040 SHALL cover: writes to addr 480 and addr 511 -> o_we stays 0, o_drop_cnt=2; 300 such writes -> o_drop_cnt=255.
REQ-041 SHALL cover: i_rst_n low at clear address 200 -> o_we=0 immediately, no o_clear_done, o_busy=0; after release, port 1 request at addr 7 is written.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Two-port round-robin write arbiter for a framebuffer, with a sweep-clear mode.
// Latency: an accepted write reaches o_we/o_waddr/o_wdata one cycle later; clear writes go out at one per cycle.
// Backpressure: o_ready is granted to at most one valid port per cycle and is held low while clearing.
module fb_write_arbiter #(
    parameter int                      p_depth       = 480,
    parameter int                      p_addr_width  = $clog2(p_depth),
    parameter int                      p_data_width  = 1,
    parameter logic [p_data_width-1:0] p_clear_value = '0
) (
    input  logic                    i_clk_pixel,
    input  logic                    i_rst_n,
    input  logic                    i_clear_req,
    input  logic [1:0]              i_valid,
    input  logic [p_addr_width-1:0] i_addr [2],
    input  logic [p_data_width-1:0] i_data [2],
    output logic [1:0]              o_ready,
    output logic                    o_we,
    output logic [p_addr_width-1:0] o_waddr,
    output logic [p_data_width-1:0] o_wdata,
    output logic                    o_busy,
    output logic                    o_clear_done,
    output logic [7:0]              o_drop_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [p_addr_width-1:0] last_addr = p_addr_width'(p_depth - 1);
    localparam logic [p_addr_width:0]   depth_w   = (p_addr_width + 1)'(p_depth);

    state_t                  state;
    state_t                  state_nxt;
    logic                    rr;
    logic [p_addr_width-1:0] clr_cnt;
    logic                    we_q;
    logic [p_addr_width-1:0] addr_q;
    logic [p_data_width-1:0] data_q;

    logic                    xfer;
    logic                    sel;
    logic [p_addr_width-1:0] sel_addr;
    logic [p_data_width-1:0] sel_data;
    logic                    in_range;

    // State register; reset aborts any sweep without a done pulse.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decode; grants are suppressed while reset is asserted.
    always_comb begin
        state_nxt = state;
        o_ready   = 2'b00;
        case (state)
            S_RUN: begin
                if (i_clear_req) begin
                    state_nxt = S_CLEAR;
                end else if (i_rst_n) begin
                    if (&i_valid) begin
                        o_ready[rr] = 1'b1;
                    end else begin
                        o_ready = i_valid;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_cnt == last_addr) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    assign xfer     = |o_ready;
    assign sel      = o_ready[1];
    assign sel_addr = i_addr[sel];
    assign sel_data = i_data[sel];
    assign in_range = ({1'b0, sel_addr} < depth_w);

    // Clear writes bypass the output register so the sweep has no bubble at its start.
    assign o_busy       = (state == S_CLEAR);
    assign o_clear_done = (state == S_DONE);
    assign o_we         = o_busy ? 1'b1 : we_q;
    assign o_waddr      = o_busy ? clr_cnt : addr_q;
    assign o_wdata      = o_busy ? p_clear_value : data_q;

    // Datapath: sweep counter, registered write port, round-robin pointer and drop counter.
    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr         <= 1'b0;
            clr_cnt    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            o_drop_cnt <= 8'd0;
        end else begin
            we_q <= 1'b0;
            if ((state == S_RUN) && i_clear_req) begin
                clr_cnt <= '0;
            end else if (state == S_CLEAR) begin
                // Track the sweep so the held address afterwards is the last one cleared.
                clr_cnt <= clr_cnt + 1'b1;
                addr_q  <= clr_cnt;
                data_q  <= p_clear_value;
            end
            if (xfer) begin
                rr <= ~sel;
                if (in_range) begin
                    we_q   <= 1'b1;
                    addr_q <= sel_addr;
                    data_q <= sel_data;
                end else if (o_drop_cnt != 8'hFF) begin
                    o_drop_cnt <= o_drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: table-driven arbitration vectors with a
// write scoreboard, plus hand-written clear-sweep, saturation and reset-abort sequences.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle or 1ns after it.
module tb_fb_write_arbiter;

    logic       clk;
    logic       rst_n;
    logic       clear_req;
    logic [1:0] valid;
    logic [8:0] addr [2];
    logic [0:0] data [2];
    logic [1:0] ready;
    logic       we;
    logic [8:0] waddr;
    logic [0:0] wdata;
    logic       busy;
    logic       clear_done;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fb_write_arbiter dut (
        .i_clk_pixel (clk),
        .i_rst_n     (rst_n),
        .i_clear_req (clear_req),
        .i_valid     (valid),
        .i_addr      (addr),
        .i_data      (data),
        .o_ready     (ready),
        .o_we        (we),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_busy      (busy),
        .o_clear_done(clear_done),
        .o_drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [8:0] a0;
        logic [0:0] d0;
        logic [8:0] a1;
        logic [0:0] d1;
        logic [1:0] ready;
    } vec_t;

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [0:0] data;
        logic       chk_hold;
    } exp_t;

    exp_t       sb [$];
    logic [8:0] last_addr;
    logic [0:0] last_data;
    vec_t       vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one vector for one cycle, check the grant, and score the registered write.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   k;
        valid   = v.valid;
        addr[0] = v.a0;
        data[0] = v.d0;
        addr[1] = v.a1;
        data[1] = v.d1;
        #4;
        check($sformatf("vec%0d_ready", idx), ready, v.ready);
        e.we       = 1'b0;
        e.addr     = last_addr;
        e.data     = last_data;
        e.chk_hold = (v.ready == 2'b00);
        if (v.ready != 2'b00) begin
            k = v.ready[1] ? 1 : 0;
            if ((k ? v.a1 : v.a0) < 9'd480) begin
                e.we      = 1'b1;
                e.addr    = k ? v.a1 : v.a0;
                e.data    = k ? v.d1 : v.d0;
                last_addr = e.addr;
                last_data = e.data;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check($sformatf("vec%0d_we", idx), we, got.we);
        if (got.we || got.chk_hold) begin
            check($sformatf("vec%0d_waddr", idx), waddr, got.addr);
            check($sformatf("vec%0d_wdata", idx), wdata, got.data);
        end
    endtask

    initial begin
        int clr_ok;
        int rdy_hi;
        int done_cnt;
        int we_cnt;

        vecs[0]  = '{2'b11, 9'd1,   1'b1, 9'd2,   1'b0, 2'b01};
        vecs[1]  = '{2'b11, 9'd3,   1'b0, 9'd4,   1'b1, 2'b10};
        vecs[2]  = '{2'b11, 9'd5,   1'b1, 9'd6,   1'b0, 2'b01};
        vecs[3]  = '{2'b11, 9'd7,   1'b0, 9'd8,   1'b1, 2'b10};
        vecs[4]  = '{2'b01, 9'd5,   1'b1, 9'd0,   1'b0, 2'b01};
        vecs[5]  = '{2'b00, 9'd0,   1'b0, 9'd0,   1'b0, 2'b00};
        vecs[6]  = '{2'b11, 9'd9,   1'b0, 9'd10,  1'b1, 2'b10};
        vecs[7]  = '{2'b10, 9'd0,   1'b0, 9'd12,  1'b0, 2'b10};
        vecs[8]  = '{2'b01, 9'd480, 1'b1, 9'd0,   1'b0, 2'b01};
        vecs[9]  = '{2'b10, 9'd0,   1'b0, 9'd511, 1'b1, 2'b10};
        vecs[10] = '{2'b00, 9'd0,   1'b0, 9'd0,   1'b0, 2'b00};

        rst_n     = 1'b0;
        clear_req = 1'b0;
        valid     = 2'b11;
        addr[0]   = 9'd1;
        addr[1]   = 9'd2;
        data[0]   = 1'b1;
        data[1]   = 1'b1;
        last_addr = 9'd0;
        last_data = 1'b0;

        // Reset state, with both requesters valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 2'b00);
        check("rst_we", we, 1'b0);
        check("rst_waddr", waddr, 9'd0);
        check("rst_wdata", wdata, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", clear_done, 1'b0);
        check("rst_drop", drop_cnt, 8'd0);
        rst_n = 1'b1;

        // Arbitration table: alternating grants, single requesters, out-of-range drops.
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end
        check("drop_after_table", drop_cnt, 8'd2);

        // Transfer accepted right before the clear request must still be emitted.
        run_vec('{2'b01, 9'd3, 1'b1, 9'd0, 1'b0, 2'b01}, 11);
        clear_req = 1'b1;
        valid     = 2'b11;
        #4;
        check("clr_req_ready", ready, 2'b00);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        clr_ok    = 0;
        rdy_hi    = 0;
        done_cnt  = 0;
        for (int i = 0; i < 480; i++) begin
            if (we && busy && (waddr == 9'(i)) && (wdata == 1'b0)) clr_ok++;
            if (ready != 2'b00) rdy_hi++;
            if (clear_done) done_cnt++;
            clear_req = (i == 100);
            @(posedge clk);
            #1;
        end
        clear_req = 1'b0;
        check("clear_writes", clr_ok, 480);
        check("clear_ready_low", rdy_hi, 0);
        check("clear_early_done", done_cnt, 0);
        check("done_pulse", clear_done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_we", we, 1'b0);
        check("done_ready", ready, 2'b00);
        check("done_waddr_hold", waddr, 9'd479);
        valid = 2'b00;
        @(posedge clk);
        #1;
        check("after_done_pulse", clear_done, 1'b0);
        check("after_done_busy", busy, 1'b0);

        // Drop counter saturation with continuous out-of-range writes.
        valid   = 2'b01;
        addr[0] = 9'd500;
        rdy_hi  = 0;
        we_cnt  = 0;
        for (int i = 0; i < 300; i++) begin
            #4;
            if (ready == 2'b01) rdy_hi++;
            @(posedge clk);
            #1;
            if (we) we_cnt++;
        end
        valid = 2'b00;
        check("sat_grants", rdy_hi, 300);
        check("sat_no_write", we_cnt, 0);
        check("sat_drop", drop_cnt, 8'd255);

        // Reset asserted mid-sweep at clear address 200.
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_clear_addr", waddr, 9'd200);
        valid   = 2'b11;
        rst_n   = 1'b0;
        #1;
        check("abort_we", we, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 2'b00);
        done_cnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (clear_done) done_cnt++;
        end
        rst_n   = 1'b1;
        valid   = 2'b10;
        addr[1] = 9'd7;
        data[1] = 1'b1;
        #4;
        if (clear_done) done_cnt++;
        check("abort_no_done", done_cnt, 0);
        check("post_rst_ready", ready, 2'b10);
        @(posedge clk);
        #1;
        valid = 2'b00;
        check("post_rst_we", we, 1'b1);
        check("post_rst_waddr", waddr, 9'd7);
        check("post_rst_wdata", wdata, 1'b1);
        check("post_rst_drop", drop_cnt, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
